// File: rtl/mutual_system_n_pkg.sv
// Shared definitions for the parametrised mutual-exclusion system:
// client state encoding and the round-robin winner search.
package mutual_system_n_pkg;

   localparam int STATE_W  = 2;
   localparam int MAX_CLNT = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_I = 2'd0,
      ST_T = 2'd1,
      ST_C = 2'd2,
      ST_E = 2'd3
   } state_e;

   // One-hot winner: first set request strictly after ptr, wrapping modulo n.
   function automatic logic [MAX_CLNT-1:0] rr_pick(input logic [MAX_CLNT-1:0] req,
                                                   input logic [3:0]          ptr,
                                                   input int                  n);
      logic [MAX_CLNT-1:0] gnt;
      logic                found;
      logic [3:0]          sel;
      gnt   = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_CLNT; k++) begin
         sel = 4'((int'(ptr) + k) % n);
         if (k <= n && !found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/mutual_system_n_arbiter.sv
// Crit arbiter: lowest-index or round-robin one-hot grant over the request
// vector, owning the round-robin pointer register.
module mutual_arbiter
   import mutual_system_n_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int PTR_W       = $clog2(NUM_CLIENTS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_CLIENTS-1:0] req_i,
   input  logic                   arb_rr_i,
   output logic [NUM_CLIENTS-1:0] gnt_o,
   output logic [PTR_W-1:0]       rr_ptr_o
);

   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [MAX_CLNT-1:0] rr_gnt;

   assign rr_gnt = rr_pick(MAX_CLNT'(req_i), 4'(rr_ptr_q), NUM_CLIENTS);

   always_comb begin
      if (arb_rr_i) gnt_o = rr_gnt[NUM_CLIENTS-1:0];
      else          gnt_o = req_i & (~req_i + NUM_CLIENTS'(1));
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (gnt_o[i]) rr_ptr_d = PTR_W'(i);
      end
   end

   // Reset to the last client so client 0 is searched first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= PTR_W'(NUM_CLIENTS - 1);
      else         rr_ptr_q <= rr_ptr_d;
   end

   assign rr_ptr_o = rr_ptr_q;

endmodule

// File: rtl/mutual_system_n.sv
// N-client mutual-exclusion system: client states, shared token, Crit
// arbitration, saturating grant counter and sticky safety monitor.
module mutual_system_n
   import mutual_system_n_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int ARB_RR      = 0,
   parameter int CNT_W       = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_CLIENTS-1:0]         io_en_a,
   output logic [STATE_W*NUM_CLIENTS-1:0] io_n_state,
   output logic                           io_x,
   output logic [NUM_CLIENTS-1:0]         io_grant,
   output logic [CNT_W-1:0]               io_crit_count,
   output logic                           io_violation
);

   localparam int PTR_W = $clog2(NUM_CLIENTS);

   logic [STATE_W*NUM_CLIENTS-1:0] state_q, state_d;
   logic                           x_q, x_d;
   logic [NUM_CLIENTS-1:0]         grant_q;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           viol_q, viol_d;
   logic [NUM_CLIENTS-1:0]         req, gnt;
   logic [PTR_W-1:0]               rr_ptr;
   logic                           idle_any;
   logic [4:0]                     ce_cnt;

   // A request is an enabled client in T while the token is free.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         req[i] = io_en_a[i] && (state_q[STATE_W*i +: STATE_W] == ST_T) && x_q;
      end
   end

   mutual_arbiter #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .PTR_W       (PTR_W)
   ) u_arb (
      .clk_i    (clock),
      .rst_ni   (reset),
      .req_i    (req),
      .arb_rr_i (1'(ARB_RR)),
      .gnt_o    (gnt),
      .rr_ptr_o (rr_ptr)
   );

   always_comb begin
      state_d  = state_q;
      idle_any = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (io_en_a[i]) begin
            case (state_q[STATE_W*i +: STATE_W])
               ST_I: state_d[STATE_W*i +: STATE_W] = ST_T;
               ST_T: if (gnt[i]) state_d[STATE_W*i +: STATE_W] = ST_C;
               ST_C: state_d[STATE_W*i +: STATE_W] = ST_E;
               default: begin
                  state_d[STATE_W*i +: STATE_W] = ST_I;
                  idle_any = 1'b1;
               end
            endcase
         end
      end
      if (|gnt)         x_d = 1'b0;
      else if (idle_any) x_d = 1'b1;
      else               x_d = x_q;
   end

   always_comb begin
      ce_cnt = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (state_q[STATE_W*i+1]) ce_cnt = ce_cnt + 5'd1;
      end
      viol_d = viol_q || (ce_cnt > 5'd1) || (x_q && (ce_cnt != 5'd0));
      cnt_d  = cnt_q;
      if (|gnt && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= '0;
         x_q     <= 1'b1;
         grant_q <= '0;
         cnt_q   <= '0;
         viol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         grant_q <= gnt;
         cnt_q   <= cnt_d;
         viol_q  <= viol_d;
      end
   end

   assign io_n_state    = state_q;
   assign io_x          = x_q;
   assign io_grant      = grant_q;
   assign io_crit_count = cnt_q;
   assign io_violation  = viol_q;

endmodule

// File: tb/tb_mutual_system_n.sv
// Directed bench: fixed-priority, round-robin and narrow-counter instances
// of mutual_system_n with hand-computed expectations.
module tb_mutual_system_n;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] en_fp = '0, en_rr = '0, en_sat = '0;

   logic [5:0] st_fp, st_rr, st_sat;
   logic       x_fp, x_rr, x_sat;
   logic [2:0] g_fp, g_rr, g_sat;
   logic [7:0] cnt_fp, cnt_rr;
   logic [1:0] cnt_sat;
   logic       v_fp, v_rr, v_sat;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] en;
      logic [5:0] st;
      logic       x;
      logic [2:0] g;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[12];

   mutual_system_n #(.NUM_CLIENTS(3), .ARB_RR(0), .CNT_W(8)) dut_fp (
      .clock(clock), .reset(reset), .io_en_a(en_fp), .io_n_state(st_fp), .io_x(x_fp),
      .io_grant(g_fp), .io_crit_count(cnt_fp), .io_violation(v_fp));

   mutual_system_n #(.NUM_CLIENTS(3), .ARB_RR(1), .CNT_W(8)) dut_rr (
      .clock(clock), .reset(reset), .io_en_a(en_rr), .io_n_state(st_rr), .io_x(x_rr),
      .io_grant(g_rr), .io_crit_count(cnt_rr), .io_violation(v_rr));

   mutual_system_n #(.NUM_CLIENTS(3), .ARB_RR(0), .CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .io_en_a(en_sat), .io_n_state(st_sat), .io_x(x_sat),
      .io_grant(g_sat), .io_crit_count(cnt_sat), .io_violation(v_sat));

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rr_step(input logic [2:0] en, input logic [2:0] exp_g, input string name);
      en_rr = en;
      tick();
      chk(name, 32'(g_rr), 32'(exp_g));
   endtask

   initial begin
      logic [5:0] exp_st;
      int         w;

      // client 0 full cycle, then contention under fixed priority
      vecs[0]  = '{3'b001, 6'b000001, 1'b1, 3'b000, 8'd0};
      vecs[1]  = '{3'b001, 6'b000010, 1'b0, 3'b001, 8'd1};
      vecs[2]  = '{3'b001, 6'b000011, 1'b0, 3'b000, 8'd1};
      vecs[3]  = '{3'b001, 6'b000000, 1'b1, 3'b000, 8'd1};
      vecs[4]  = '{3'b111, 6'b010101, 1'b1, 3'b000, 8'd1};
      vecs[5]  = '{3'b111, 6'b010110, 1'b0, 3'b001, 8'd2};
      vecs[6]  = '{3'b000, 6'b010110, 1'b0, 3'b000, 8'd2};
      vecs[7]  = '{3'b000, 6'b010110, 1'b0, 3'b000, 8'd2};
      vecs[8]  = '{3'b110, 6'b010110, 1'b0, 3'b000, 8'd2};
      vecs[9]  = '{3'b001, 6'b010111, 1'b0, 3'b000, 8'd2};
      vecs[10] = '{3'b001, 6'b010100, 1'b1, 3'b000, 8'd2};
      vecs[11] = '{3'b110, 6'b011000, 1'b0, 3'b010, 8'd3};

      #12;
      chk("reset_state_held", 32'(st_fp), 32'd0);
      chk("reset_x_held", 32'(x_fp), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk("reset_state", 32'(st_fp), 32'd0);
      chk("reset_x", 32'(x_fp), 32'd1);
      chk("reset_viol", 32'(v_fp), 32'd0);
      chk("reset_cnt", 32'(cnt_fp), 32'd0);
      chk("reset_grant", 32'(g_fp), 32'd0);
      chk("reset_rr_state", 32'(st_rr), 32'd0);
      chk("reset_sat_cnt", 32'(cnt_sat), 32'd0);

      for (int i = 0; i < 12; i++) begin
         en_fp = vecs[i].en;
         tick();
         chk($sformatf("fp_state[%0d]", i), 32'(st_fp), 32'(vecs[i].st));
         chk($sformatf("fp_x[%0d]", i), 32'(x_fp), 32'(vecs[i].x));
         chk($sformatf("fp_grant[%0d]", i), 32'(g_fp), 32'(vecs[i].g));
         chk($sformatf("fp_cnt[%0d]", i), 32'(cnt_fp), 32'(vecs[i].cnt));
         chk($sformatf("fp_viol[%0d]", i), 32'(v_fp), 32'd0);
      end
      en_fp = '0;

      // round-robin: winner rotates 0,1,2 then wraps to 0
      rr_step(3'b111, 3'b000, "rr_try_all");
      for (int r = 0; r < 4; r++) begin
         w = r % 3;
         rr_step(3'b111, 3'(1 << w), $sformatf("rr_grant_round%0d", r));
         exp_st = 6'b010101;
         exp_st[2*w +: 2] = 2'b10;
         chk($sformatf("rr_state_round%0d", r), 32'(st_rr), 32'(exp_st));
         chk($sformatf("rr_x_round%0d", r), 32'(x_rr), 32'd0);
         rr_step(3'(1 << w), 3'b000, "rr_exit");
         rr_step(3'(1 << w), 3'b000, "rr_idle");
         chk("rr_x_after_idle", 32'(x_rr), 32'd1);
         rr_step(3'(1 << w), 3'b000, "rr_retry");
      end
      chk("rr_count", 32'(cnt_rr), 32'd4);
      en_rr = '0;

      // 2-bit counter saturates at 3
      for (int k = 1; k <= 5; k++) begin
         en_sat = 3'b001;
         tick();
         tick();
         chk($sformatf("sat_grant%0d", k), 32'(g_sat), 32'd1);
         chk($sformatf("sat_cnt%0d", k), 32'(cnt_sat), 32'((k > 3) ? 3 : k));
         tick();
         tick();
      end
      en_sat = '0;

      // client 1 in C and client 2 in E together must trip the monitor
      force dut_fp.state_q = 6'b111000;
      #1;
      chk("viol_before_edge", 32'(v_fp), 32'd0);
      tick();
      chk("viol_set", 32'(v_fp), 32'd1);
      release dut_fp.state_q;
      tick();
      tick();
      chk("viol_sticky", 32'(v_fp), 32'd1);
      chk("viol_other_dut", 32'(v_rr), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_viol", 32'(v_fp), 32'd0);
      chk("async_reset_state", 32'(st_fp), 32'd0);
      chk("async_reset_x", 32'(x_fp), 32'd1);
      chk("async_reset_cnt", 32'(cnt_fp), 32'd0);
      chk("async_reset_sat_cnt", 32'(cnt_sat), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk("post_reset_viol", 32'(v_fp), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
